// File: rtl/npu_window_sram_if.sv
// npu_window_sram_if: tile load stream, load status and the two window read ports
interface npu_window_sram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SRAM_ADDR_WIDTH = 4
);
  logic load_start;
  logic [SRAM_ADDR_WIDTH:0] load_len;
  logic wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic wr_ready;
  logic loaded;
  logic [SRAM_ADDR_WIDTH:0] load_count;
  logic [SRAM_ADDR_WIDTH-1:0] rd_addr1;
  logic [DATA_WIDTH-1:0] rd_data1;
  logic [SRAM_ADDR_WIDTH-1:0] rd_addr2;
  logic [DATA_WIDTH-1:0] rd_data2;
  modport master (
    output load_start, load_len, wr_valid, wr_data, rd_addr1, rd_addr2,
    input  wr_ready, loaded, load_count, rd_data1, rd_data2
  );
  modport slave (
    input  load_start, load_len, wr_valid, wr_data, rd_addr1, rd_addr2,
    output wr_ready, loaded, load_count, rd_data1, rd_data2
  );
endinterface

// File: rtl/npu_window_sram.sv
// npu_window_sram: tile scratchpad with streamed fill and two 1-cycle read ports.
// NPU_SRAM_ZERO_PAD_EN: reads at or beyond the current load count return 0.
module npu_window_sram #(
  parameter int DATA_WIDTH = 8,
  parameter int SRAM_ADDR_WIDTH = 4,
  parameter int SRAM_DEPTH = 16
) (
  input logic clk,
  input logic rst,
  npu_window_sram_if.slave bus
);
  localparam int AW = SRAM_ADDR_WIDTH;
  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] mem [SRAM_DEPTH];
  logic [AW:0] len, count, count_nxt, eff_len, lim;
  logic wr_ready, loaded, we;
  logic [DATA_WIDTH-1:0] rd_data1, rd_data2, q1, q2;
  assign eff_len = (bus.load_len > (AW+1)'(SRAM_DEPTH)) ? (AW+1)'(SRAM_DEPTH) : bus.load_len;
  assign count_nxt = count + (AW+1)'(1);
  assign we = (state == LOAD) && bus.wr_valid;
`ifdef NPU_SRAM_ZERO_PAD_EN
  assign lim = count;
`else
  assign lim = (AW+1)'(SRAM_DEPTH);
`endif
  // count never exceeds the depth, so lim also masks out-of-range addresses
  assign q1 = ({1'b0, bus.rd_addr1} >= lim) ? '0 : mem[bus.rd_addr1];
  assign q2 = ({1'b0, bus.rd_addr2} >= lim) ? '0 : mem[bus.rd_addr2];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      len <= '0;
      count <= '0;
      wr_ready <= 1'b0;
      loaded <= 1'b0;
      rd_data1 <= '0;
      rd_data2 <= '0;
    end else begin
      rd_data1 <= q1;
      rd_data2 <= q2;
      case (state)
        LOAD: if (bus.wr_valid) begin
          count <= count_nxt;
          if (count_nxt == len) begin
            state <= FULL;
            wr_ready <= 1'b0;
            loaded <= 1'b1;
          end
        end
        default: if (bus.load_start) begin
          len <= eff_len;
          count <= '0;
          state <= (eff_len == '0) ? FULL : LOAD;
          wr_ready <= (eff_len != '0);
          loaded <= (eff_len == '0);
        end
      endcase
    end
  // storage is deliberately not reset; the write address is the running count
  always_ff @(posedge clk)
    if (we) mem[count[AW-1:0]] <= bus.wr_data;
  assign bus.wr_ready = wr_ready;
  assign bus.loaded = loaded;
  assign bus.load_count = count;
  assign bus.rd_data1 = rd_data1;
  assign bus.rd_data2 = rd_data2;
endmodule
